fifo_read_ctrl: RTL and testbench
=================================

// Module: fifo_read_ctrl
// PURPOSE
//   Read-side controller of the dual-clock async FIFO; companion to the write-side controller.
//   Lives in the read clock domain:
//   - generates the read address for the shared dual-port RAM;
//   - publishes the Gray-coded read pointer to the write domain;
//   - computes empty, almost_empty, occupancy and an underflow flag from the synchronised write pointer.
// PARAMETERS
//   ADDR_W    3   RAM address width; depth = 2**ADDR_W (8); pointers are ADDR_W+1 bits
//   AE_LEVEL  1   almost_empty asserts when occupancy <= AE_LEVEL (range 0..2**ADDR_W-1)
// PORTS
//   clk           in   1         read-domain clock
//   rst           in   1         reset, asynchronous, active-low
//   inc           in   1         read request from consumer
//   sync_wptr     in   ADDR_W+1  Gray write pointer, already passed through external 2-FF sync in clk domain
//   raddr         out  ADDR_W    RAM read address; RAM read data is combinational on raddr
//   gray_rd_ptr   out  ADDR_W+1  registered Gray read pointer, sent to write-domain synchroniser
//   empty         out  1         FIFO empty (registered)
//   almost_empty  out  1         occupancy <= AE_LEVEL (registered)
//   rd_count      out  ADDR_W+1  conservative occupancy 0..2**ADDR_W (registered)
//   underflow     out  1         sticky: read attempted while empty
// BEHAVIOUR
//   - Reset (rst=0, async): rptr=0, gray_rd_ptr=0, raddr=0, empty=1, almost_empty=1, rd_count=0, underflow=0.
//   - rd_fire = inc & ~empty; rptr_next = rptr + rd_fire, modulo 2**(ADDR_W+1).
//   - Per posedge clk:
//     - rptr <= rptr_next;
//     - gray_rd_ptr <= rptr_next ^ (rptr_next >> 1);
//     - empty <= (gray(rptr_next) == sync_wptr);
//     - rd_count <= gray2bin(sync_wptr) - rptr_next (mod 2**(ADDR_W+1));
//     - almost_empty <= (that count <= AE_LEVEL).
//   - raddr = rptr[ADDR_W-1:0], combinational from the register.
//     - Data at raddr is valid while empty=0.
//     - Consumer takes the word in the cycle it asserts inc with empty=0.
//   - gray_rd_ptr is not lagged: it equals gray(rptr) every cycle, so only one bit changes per increment.
//   - Latency:
//     - a sync_wptr change is reflected in empty/rd_count/almost_empty one clk later;
//     - a read is reflected in raddr and gray_rd_ptr one clk later.
//   - Occupancy is pessimistic, never optimistic: sync lag only under-reports.
//     - rd_count never exceeds 2**ADDR_W for legal writer behaviour.
//   - Read on empty (inc=1, empty=1):
//     - rptr, raddr and gray_rd_ptr hold;
//     - underflow <= 1 and stays 1 until reset.
//   - Simultaneous read and write-pointer advance: both folded into the same next-state computation.
//     - empty stays 0 if the advance replaces the read word.
//   - Wrap-around:
//     - raddr wraps 2**ADDR_W-1 -> 0;
//     - rptr wraps 2**(ADDR_W+1)-1 -> 0, MSB toggles once per lap.
//   - Reset mid-operation: all outputs return to reset values immediately, independent of clk.
//     - Both FIFO domains are reset together at system level.
// TESTING
//   1. Hold rst=0 -> empty=1, almost_empty=1, raddr=0, gray_rd_ptr=0, rd_count=0, underflow=0.
//   2. sync_wptr=4'b0001 -> next edge empty=0, rd_count=1, almost_empty=1.
//      Then inc for 1 cycle -> raddr=1, gray_rd_ptr=4'b0001, empty=1.
//   3. sync_wptr=4'b1100 (gray 8) from reset -> rd_count=8, almost_empty=0.
//      8 back-to-back inc -> raddr 0..7 then 0, gray_rd_ptr=4'b1100, empty=1 after 8th read.
//   4. inc=1 while empty=1 -> raddr/gray_rd_ptr unchanged, underflow=1.
//      underflow stays 1 after more data arrives; clears only on rst.
//   5. Writer model advances sync_wptr in Gray, 20 words, reader reads continuously.
//      -> rptr wraps 15->0; each gray_rd_ptr step has Hamming distance 1.
//      -> data order preserved, no underflow.
//   6. rd_count=5, assert rst between clock edges -> all outputs take reset values before next posedge.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_read_ctrl
//  Description : Read-side pointer/flag controller of a dual-clock async FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_ctrl #(
    parameter int ADDR_W   = 3,
    parameter int AE_LEVEL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic [ADDR_W:0]   sync_wptr,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W:0]   gray_rd_ptr,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_count,
    output logic              underflow
);

    localparam logic [ADDR_W:0] c_AE_LEVEL = AE_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] c_ZERO     = '0;

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDR_W:0] r_rptr;
    logic [ADDR_W:0] r_gray;
    logic            r_empty;
    logic            r_almost_empty;
    logic [ADDR_W:0] r_count;
    logic            r_underflow;

    logic            w_rd_fire;
    logic [ADDR_W:0] w_rptr_next;
    logic [ADDR_W:0] w_gray_next;
    logic [ADDR_W:0] w_wbin;
    logic [ADDR_W:0] w_count_next;

    always_comb begin
        w_rd_fire    = inc & ~r_empty;
        w_rptr_next  = r_rptr + {c_ZERO[ADDR_W:1], w_rd_fire};
        w_gray_next  = w_rptr_next ^ (w_rptr_next >> 1);
        w_wbin       = gray2bin(sync_wptr);
        // Sync lag means w_wbin can only be stale-low, so this never over-reports.
        w_count_next = w_wbin - w_rptr_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rptr         <= '0;
            r_gray         <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_count        <= '0;
            r_underflow    <= 1'b0;
        end else begin
            r_rptr         <= w_rptr_next;
            r_gray         <= w_gray_next;
            r_empty        <= (w_gray_next == sync_wptr);
            r_almost_empty <= (w_count_next <= c_AE_LEVEL);
            r_count        <= w_count_next;
            if (inc && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign raddr        = r_rptr[ADDR_W-1:0];
    assign gray_rd_ptr  = r_gray;
    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign rd_count     = r_count;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_read_ctrl
//  Description : Directed self-checking bench for fifo_read_ctrl (ADDR_W=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_ctrl;

    logic       clk;
    logic       rst;
    logic       inc;
    logic [3:0] sync_wptr;
    logic [2:0] raddr;
    logic [3:0] gray_rd_ptr;
    logic       empty;
    logic       almost_empty;
    logic [3:0] rd_count;
    logic       underflow;

    int n_cmp = 0;
    int n_err = 0;

    fifo_read_ctrl #(.ADDR_W(3), .AE_LEVEL(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .inc          (inc),
        .sync_wptr    (sync_wptr),
        .raddr        (raddr),
        .gray_rd_ptr  (gray_rd_ptr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_count     (rd_count),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] to_gray(input int b);
        logic [3:0] v;
        v = b[3:0];
        return v ^ (v >> 1);
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        inc = 1'b0;
        sync_wptr = 4'b0000;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        step();
        n_cmp++; if (empty !== 1'b1)        begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
        n_cmp++; if (almost_empty !== 1'b1) begin n_err++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
        n_cmp++; if (raddr !== 3'd0)        begin n_err++; $display("FAIL reset_raddr got=%0d exp=0", raddr); end
        n_cmp++; if (gray_rd_ptr !== 4'd0)  begin n_err++; $display("FAIL reset_gray got=%b exp=0000", gray_rd_ptr); end
        n_cmp++; if (rd_count !== 4'd0)     begin n_err++; $display("FAIL reset_count got=%0d exp=0", rd_count); end
        n_cmp++; if (underflow !== 1'b0)    begin n_err++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
        rst = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        sync_wptr = 4'b0001;
        step();
        n_cmp++; if (empty !== 1'b0)        begin n_err++; $display("FAIL single_empty got=%b exp=0", empty); end
        n_cmp++; if (rd_count !== 4'd1)     begin n_err++; $display("FAIL single_count got=%0d exp=1", rd_count); end
        n_cmp++; if (almost_empty !== 1'b1) begin n_err++; $display("FAIL single_ae got=%b exp=1", almost_empty); end
        inc = 1'b1;
        step();
        inc = 1'b0;
        n_cmp++; if (raddr !== 3'd1)          begin n_err++; $display("FAIL single_raddr got=%0d exp=1", raddr); end
        n_cmp++; if (gray_rd_ptr !== 4'b0001) begin n_err++; $display("FAIL single_gray got=%b exp=0001", gray_rd_ptr); end
        n_cmp++; if (empty !== 1'b1)          begin n_err++; $display("FAIL single_empty_after got=%b exp=1", empty); end
        n_cmp++; if (rd_count !== 4'd0)       begin n_err++; $display("FAIL single_count_after got=%0d exp=0", rd_count); end
    endtask

    task automatic test_almost_empty();
        do_reset();
        sync_wptr = 4'b0011;
        step();
        n_cmp++; if (rd_count !== 4'd2)     begin n_err++; $display("FAIL ae_count2 got=%0d exp=2", rd_count); end
        n_cmp++; if (almost_empty !== 1'b0) begin n_err++; $display("FAIL ae_at2 got=%b exp=0", almost_empty); end
        inc = 1'b1;
        step();
        inc = 1'b0;
        n_cmp++; if (rd_count !== 4'd1)     begin n_err++; $display("FAIL ae_count1 got=%0d exp=1", rd_count); end
        n_cmp++; if (almost_empty !== 1'b1) begin n_err++; $display("FAIL ae_at1 got=%b exp=1", almost_empty); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        sync_wptr = 4'b1100;
        step();
        n_cmp++; if (rd_count !== 4'd8)     begin n_err++; $display("FAIL b2b_count got=%0d exp=8", rd_count); end
        n_cmp++; if (almost_empty !== 1'b0) begin n_err++; $display("FAIL b2b_ae got=%b exp=0", almost_empty); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (raddr !== i[2:0]) begin n_err++; $display("FAIL b2b_raddr[%0d] got=%0d exp=%0d", i, raddr, i); end
            n_cmp++; if (empty !== 1'b0)   begin n_err++; $display("FAIL b2b_empty[%0d] got=%b exp=0", i, empty); end
            inc = 1'b1;
            step();
        end
        inc = 1'b0;
        n_cmp++; if (raddr !== 3'd0)          begin n_err++; $display("FAIL b2b_raddr_wrap got=%0d exp=0", raddr); end
        n_cmp++; if (gray_rd_ptr !== 4'b1100) begin n_err++; $display("FAIL b2b_gray got=%b exp=1100", gray_rd_ptr); end
        n_cmp++; if (empty !== 1'b1)          begin n_err++; $display("FAIL b2b_empty_end got=%b exp=1", empty); end
        n_cmp++; if (rd_count !== 4'd0)       begin n_err++; $display("FAIL b2b_count_end got=%0d exp=0", rd_count); end
    endtask

    task automatic test_underflow();
        do_reset();
        step();
        inc = 1'b1;
        step();
        inc = 1'b0;
        n_cmp++; if (raddr !== 3'd0)        begin n_err++; $display("FAIL uf_raddr got=%0d exp=0", raddr); end
        n_cmp++; if (gray_rd_ptr !== 4'd0)  begin n_err++; $display("FAIL uf_gray got=%b exp=0000", gray_rd_ptr); end
        n_cmp++; if (underflow !== 1'b1)    begin n_err++; $display("FAIL uf_set got=%b exp=1", underflow); end
        sync_wptr = 4'b0001;
        step();
        step();
        n_cmp++; if (empty !== 1'b0)        begin n_err++; $display("FAIL uf_data_empty got=%b exp=0", empty); end
        n_cmp++; if (underflow !== 1'b1)    begin n_err++; $display("FAIL uf_sticky got=%b exp=1", underflow); end
        do_reset();
        n_cmp++; if (underflow !== 1'b0)    begin n_err++; $display("FAIL uf_clear got=%b exp=0", underflow); end
    endtask

    task automatic test_stream();
        int mem [8];
        int wbin;
        int rbin;
        int expect_word;
        bit fired_prev;
        logic [3:0] gray_prev;
        do_reset();
        wbin = 0;
        rbin = 0;
        expect_word = 0;
        fired_prev = 1'b0;
        gray_prev = 4'b0000;
        for (int cyc = 0; cyc < 200 && rbin < 20; cyc++) begin
            step();
            if (fired_prev) begin
                n_cmp++; if ($countones(gray_prev ^ gray_rd_ptr) != 1) begin n_err++; $display("FAIL stream_hamming got=%b prev=%b exp_dist=1", gray_rd_ptr, gray_prev); end
            end
            n_cmp++; if (gray_rd_ptr !== to_gray(rbin)) begin n_err++; $display("FAIL stream_gray got=%b exp=%b", gray_rd_ptr, to_gray(rbin)); end
            gray_prev = gray_rd_ptr;
            if (!empty) begin
                n_cmp++; if (mem[raddr] !== expect_word) begin n_err++; $display("FAIL stream_data got=%0d exp=%0d", mem[raddr], expect_word); end
                expect_word++;
                rbin++;
                inc = 1'b1;
                fired_prev = 1'b1;
            end else begin
                inc = 1'b0;
                fired_prev = 1'b0;
            end
            if (wbin < 20 && (wbin - (rbin - int'(fired_prev))) < 8 && cyc % 3 != 2) begin
                mem[wbin % 8] = wbin;
                wbin++;
                sync_wptr = to_gray(wbin);
            end
        end
        step();
        inc = 1'b0;
        n_cmp++; if (rbin !== 20)        begin n_err++; $display("FAIL stream_reads got=%0d exp=20", rbin); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL stream_underflow got=%b exp=0", underflow); end
        n_cmp++; if (gray_rd_ptr !== to_gray(20)) begin n_err++; $display("FAIL stream_wrap_gray got=%b exp=%b", gray_rd_ptr, to_gray(20)); end
        n_cmp++; if (raddr !== 3'd4)     begin n_err++; $display("FAIL stream_wrap_raddr got=%0d exp=4", raddr); end
    endtask

    task automatic test_async_reset();
        do_reset();
        sync_wptr = 4'b0111;
        step();
        n_cmp++; if (rd_count !== 4'd5) begin n_err++; $display("FAIL ar_count_pre got=%0d exp=5", rd_count); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (rd_count !== 4'd0)     begin n_err++; $display("FAIL ar_count got=%0d exp=0", rd_count); end
        n_cmp++; if (empty !== 1'b1)        begin n_err++; $display("FAIL ar_empty got=%b exp=1", empty); end
        n_cmp++; if (almost_empty !== 1'b1) begin n_err++; $display("FAIL ar_ae got=%b exp=1", almost_empty); end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        inc = 1'b0;
        sync_wptr = 4'b0000;
        test_reset();
        test_single();
        test_almost_empty();
        test_back_to_back();
        test_underflow();
        test_stream();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
